// File: rtl/byte_frame_packer.sv
// byte_frame_packer: byte-serial framer for the HMAC core.
// Packs header (salt + password) and message blocks, zero-padded.
module byte_frame_packer #(
  parameter int SALT_BYTES   = 16,
  parameter int MAX_PW_BYTES = 16,
  parameter int BLOCK_BYTES  = 16,
  localparam int PLW = $clog2(MAX_PW_BYTES + 1),
  localparam int BLW = $clog2(BLOCK_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                i_data,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic                      i_rekey,
  output logic                      o_ien,
  output logic [8*SALT_BYTES-1:0]   o_salt,
  output logic [8*MAX_PW_BYTES-1:0] o_pw,
  output logic [PLW-1:0]            o_pw_len,
  output logic                      o_mode,
  output logic                      o_key_valid,
  input  logic                      i_key_ready,
  output logic [8*BLOCK_BYTES-1:0]  o_blk,
  output logic [BLW-1:0]            o_blk_len,
  output logic                      o_blk_valid,
  input  logic                      i_blk_ready,
  output logic [2:0]                o_err
);

  localparam int HTOT = SALT_BYTES + MAX_PW_BYTES;
  localparam int HW   = $clog2(HTOT + 1);

  localparam logic [HW-1:0]  SALT_C = HW'(SALT_BYTES);
  localparam logic [HW-1:0]  TOT_C  = HW'(HTOT);
  localparam logic [BLW-1:0] BLK_C  = BLW'(BLOCK_BYTES);

  typedef enum logic [2:0] {
    HDR_WAIT,
    HDR,
    KEY_HOLD,
    MSG_WAIT,
    MSG,
    BLK_HOLD
  } state_t;

  state_t                    state_q;
  logic                      ien_q;
  logic [8*SALT_BYTES-1:0]   salt_q;
  logic [8*MAX_PW_BYTES-1:0] pw_q;
  logic [PLW-1:0]            pw_len_q;
  logic [HW-1:0]             hcnt_q;
  logic                      mode_q;
  logic                      key_valid_q;
  logic [8*BLOCK_BYTES-1:0]  blk_q;
  logic [BLW-1:0]            blk_len_q;
  logic                      blk_valid_q;
  logic [2:0]                err_q;

  // Frame FSM: captures bytes, registers results and handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HDR_WAIT;
      ien_q       <= 1'b1;
      salt_q      <= '0;
      pw_q        <= '0;
      pw_len_q    <= '0;
      hcnt_q      <= '0;
      mode_q      <= 1'b0;
      key_valid_q <= 1'b0;
      blk_q       <= '0;
      blk_len_q   <= '0;
      blk_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      case (state_q)
        HDR_WAIT: begin
          if (i_start) begin
            state_q  <= HDR;
            ien_q    <= 1'b0;
            mode_q   <= i_mode;
            salt_q   <= {i_data, {(8*SALT_BYTES-8){1'b0}}};
            pw_q     <= '0;
            pw_len_q <= '0;
            hcnt_q   <= HW'(1);
          end
        end
        HDR: begin
          if (i_start) begin
            if (hcnt_q < TOT_C) begin
              for (int i = 0; i < SALT_BYTES; i++)
                if (hcnt_q == HW'(i))
                  salt_q[8*(SALT_BYTES-1-i) +: 8] <= i_data;
              for (int i = 0; i < MAX_PW_BYTES; i++)
                if (hcnt_q == HW'(SALT_BYTES + i))
                  pw_q[8*(MAX_PW_BYTES-1-i) +: 8] <= i_data;
              if (hcnt_q >= SALT_C)
                pw_len_q <= pw_len_q + 1'b1;
              hcnt_q <= hcnt_q + 1'b1;
            end else begin
              err_q[1] <= 1'b1;
            end
          end else if (hcnt_q <= SALT_C) begin
            // too short to hold salt plus one password byte
            err_q[0] <= 1'b1;
            salt_q   <= '0;
            pw_q     <= '0;
            pw_len_q <= '0;
            hcnt_q   <= '0;
            state_q  <= HDR_WAIT;
            ien_q    <= 1'b1;
          end else begin
            key_valid_q <= 1'b1;
            state_q     <= KEY_HOLD;
          end
        end
        KEY_HOLD: begin
          if (i_start) begin
            err_q[2] <= 1'b1;
          end else if (i_key_ready) begin
            key_valid_q <= 1'b0;
            state_q     <= MSG_WAIT;
            ien_q       <= 1'b1;
          end
        end
        MSG_WAIT: begin
          if (i_rekey) begin
            pw_q     <= '0;
            pw_len_q <= '0;
            hcnt_q   <= '0;
            if (i_start) begin
              // rekey wins: this byte opens the new header
              state_q <= HDR;
              ien_q   <= 1'b0;
              mode_q  <= i_mode;
              salt_q  <= {i_data, {(8*SALT_BYTES-8){1'b0}}};
              hcnt_q  <= HW'(1);
            end else begin
              salt_q  <= '0;
              state_q <= HDR_WAIT;
            end
          end else if (i_start) begin
            blk_q     <= {i_data, {(8*BLOCK_BYTES-8){1'b0}}};
            blk_len_q <= BLW'(1);
            state_q   <= MSG;
            ien_q     <= 1'b0;
          end
        end
        MSG: begin
          if (i_start) begin
            if (blk_len_q < BLK_C) begin
              for (int i = 0; i < BLOCK_BYTES; i++)
                if (blk_len_q == BLW'(i))
                  blk_q[8*(BLOCK_BYTES-1-i) +: 8] <= i_data;
              blk_len_q <= blk_len_q + 1'b1;
            end else begin
              err_q[1] <= 1'b1;
            end
          end else begin
            blk_valid_q <= 1'b1;
            state_q     <= BLK_HOLD;
          end
        end
        BLK_HOLD: begin
          if (i_start) begin
            err_q[2] <= 1'b1;
          end else if (i_blk_ready) begin
            blk_valid_q <= 1'b0;
            state_q     <= MSG_WAIT;
            ien_q       <= 1'b1;
          end
        end
        default: begin
          state_q <= HDR_WAIT;
          ien_q   <= 1'b1;
        end
      endcase
    end
  end

  assign o_ien       = ien_q;
  assign o_salt      = salt_q;
  assign o_pw        = pw_q;
  assign o_pw_len    = pw_len_q;
  assign o_mode      = mode_q;
  assign o_key_valid = key_valid_q;
  assign o_blk       = blk_q;
  assign o_blk_len   = blk_len_q;
  assign o_blk_valid = blk_valid_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_byte_frame_packer.sv
// tb_byte_frame_packer: directed checks of byte_frame_packer.
// Message vectors are table driven; corner cases are hand sequences.
module tb_byte_frame_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   i_data = '0;
  logic         i_start = 1'b0;
  logic         i_mode = 1'b0;
  logic         i_rekey = 1'b0;
  logic         i_key_ready = 1'b0;
  logic         i_blk_ready = 1'b0;
  logic         o_ien;
  logic [127:0] o_salt;
  logic [127:0] o_pw;
  logic [4:0]   o_pw_len;
  logic         o_mode;
  logic         o_key_valid;
  logic [127:0] o_blk;
  logic [4:0]   o_blk_len;
  logic         o_blk_valid;
  logic [2:0]   o_err;

  int nvec = 0;
  int nbad = 0;

  byte_frame_packer dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_start(i_start),
    .i_mode(i_mode), .i_rekey(i_rekey), .o_ien(o_ien),
    .o_salt(o_salt), .o_pw(o_pw), .o_pw_len(o_pw_len),
    .o_mode(o_mode), .o_key_valid(o_key_valid),
    .i_key_ready(i_key_ready), .o_blk(o_blk),
    .o_blk_len(o_blk_len), .o_blk_valid(o_blk_valid),
    .i_blk_ready(i_blk_ready), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           n;
    logic [7:0]   first;
    logic [7:0]   step;
    logic [127:0] blk;
    logic [4:0]   len;
    logic [2:0]   err;
  } vec_t;

  vec_t vt[3];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the frame-end edge
  task automatic frame(input int n, input logic [7:0] first,
                       input logic [7:0] step, input logic rk,
                       input logic md);
    for (int k = 0; k < n; k++) begin
      i_start = 1'b1;
      i_data  = first + 8'(k) * step;
      i_rekey = rk && (k == 0);
      i_mode  = (k == 0) ? md : ~md;
      @(negedge clk);
    end
    i_start = 1'b0;
    i_rekey = 1'b0;
    i_data  = '0;
    @(negedge clk);
  endtask

  task automatic key_ack();
    i_key_ready = 1'b1;
    @(negedge clk);
    i_key_ready = 1'b0;
    chk("key_valid_drop", o_key_valid, 0);
    chk("ien_after_key", o_ien, 1);
  endtask

  task automatic blk_ack();
    i_blk_ready = 1'b1;
    @(negedge clk);
    i_blk_ready = 1'b0;
    chk("blk_valid_drop", o_blk_valid, 0);
    chk("ien_after_blk", o_ien, 1);
  endtask

  initial begin
    vt[0] = '{3, 8'haa, 8'h11, {24'haabbcc, 104'h0}, 5'd3, 3'b000};
    vt[1] = '{1, 8'h55, 8'h00, {8'h55, 120'h0}, 5'd1, 3'b000};
    vt[2] = '{18, 8'h00, 8'h01,
              128'h000102030405060708090a0b0c0d0e0f, 5'd16, 3'b010};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ien", o_ien, 1);
    chk("rst_key_valid", o_key_valid, 0);
    chk("rst_blk_valid", o_blk_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_salt", o_salt, 0);

    // full 31-byte header
    frame(31, 8'h00, 8'h01, 1'b0, 1'b1);
    chk("hdr_salt", o_salt, 128'h000102030405060708090a0b0c0d0e0f);
    chk("hdr_pw", o_pw, 128'h101112131415161718191a1b1c1d1e00);
    chk("hdr_pw_len", o_pw_len, 15);
    chk("hdr_mode", o_mode, 1);
    chk("hdr_key_valid", o_key_valid, 1);
    chk("hdr_ien", o_ien, 0);
    repeat (2) @(negedge clk);
    chk("key_held", o_key_valid, 1);
    key_ack();

    // 16-byte block held while ready stays low
    frame(16, 8'ha0, 8'h01, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("blk16_valid_held", o_blk_valid, 1);
      chk("blk16_ien_low", o_ien, 0);
      @(negedge clk);
    end
    chk("blk16_data", o_blk, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
    chk("blk16_len", o_blk_len, 16);
    chk("blk16_keyv", o_key_valid, 0);
    blk_ack();

    for (int v = 0; v < 3; v++) begin
      frame(vt[v].n, vt[v].first, vt[v].step, 1'b0, 1'b0);
      chk($sformatf("vec%0d_valid", v), o_blk_valid, 1);
      chk($sformatf("vec%0d_blk", v), o_blk, vt[v].blk);
      chk($sformatf("vec%0d_len", v), o_blk_len, vt[v].len);
      chk($sformatf("vec%0d_err", v), o_err, vt[v].err);
      blk_ack();
    end

    // burst during BLK_HOLD is flagged and ignored
    frame(2, 8'h12, 8'h22, 1'b0, 1'b0);
    frame(3, 8'hf0, 8'h01, 1'b0, 1'b0);
    chk("burst_err", o_err, 3'b110);
    chk("burst_blk", o_blk, {16'h1234, 112'h0});
    chk("burst_len", o_blk_len, 2);
    chk("burst_valid", o_blk_valid, 1);
    blk_ack();
    frame(2, 8'h56, 8'h22, 1'b0, 1'b0);
    chk("post_burst_blk", o_blk, {16'h5678, 112'h0});
    chk("post_burst_len", o_blk_len, 2);
    blk_ack();

    // rekey alone drops the key
    i_rekey = 1'b1;
    @(negedge clk);
    i_rekey = 1'b0;
    chk("rekey_salt", o_salt, 0);
    chk("rekey_pw_len", o_pw_len, 0);
    chk("rekey_ien", o_ien, 1);

    // short header
    frame(10, 8'h01, 8'h01, 1'b0, 1'b1);
    chk("short_err", o_err, 3'b111);
    chk("short_ien", o_ien, 1);
    chk("short_keyv", o_key_valid, 0);
    chk("short_salt", o_salt, 0);

    // minimal valid header
    frame(17, 8'h20, 8'h01, 1'b0, 1'b1);
    chk("min_salt", o_salt, 128'h202122232425262728292a2b2c2d2e2f);
    chk("min_pw", o_pw, {8'h30, 120'h0});
    chk("min_pw_len", o_pw_len, 1);
    chk("min_keyv", o_key_valid, 1);
    key_ack();

    // rekey together with start opens a new header
    frame(17, 8'h40, 8'h01, 1'b1, 1'b0);
    chk("rk_salt", o_salt, 128'h404142434445464748494a4b4c4d4e4f);
    chk("rk_pw", o_pw, {8'h50, 120'h0});
    chk("rk_mode", o_mode, 0);
    chk("rk_keyv", o_key_valid, 1);
    chk("rk_blkv", o_blk_valid, 0);
    key_ack();

    // reset mid-message
    i_start = 1'b1;
    i_data  = 8'h99;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    i_start = 1'b0;
    #1;
    chk("mrst_ien", o_ien, 1);
    chk("mrst_err", o_err, 0);
    chk("mrst_blk", o_blk, 0);
    chk("mrst_blk_len", o_blk_len, 0);
    chk("mrst_salt", o_salt, 0);
    chk("mrst_pw", o_pw, 0);
    chk("mrst_mode", o_mode, 0);
    chk("mrst_valids", {o_key_valid, o_blk_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_hold_ien", o_ien, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
